// File: rtl/conv_pkg.sv
// ==========================================================================
// conv_pkg : shared types and helpers for the pooling stage
// Rev 1.0
// ==========================================================================
`default_nettype none

package conv_pkg;

  localparam int PMAX   = 4;
  localparam int ADDR_W = 8;

  localparam logic signed [7:0] MIN_S8 = 8'sh80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic [3:0] clamp_win(input logic [3:0] v, input logic [3:0] lim);
    if (v == 4'd0) begin
      return 4'd1;
    end else if (v > lim) begin
      return lim;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [3:0] clamp_stride(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_addr_gen.sv
// ==========================================================================
// pool_addr_gen : window/origin counters and DI/DO byte address generation
// Rev 1.0
// ==========================================================================
`default_nettype none

module pool_addr_gen
  import conv_pkg::*;
#(
  parameter int WIN_MAX = PMAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [7:0]        di_w,
  input  logic [7:0]        di_x_stop,
  input  logic [7:0]        di_y_stop,
  input  logic [3:0]        stride_x,
  input  logic [3:0]        stride_y,
  input  logic [3:0]        p_w,
  input  logic [3:0]        p_h,
  input  logic [7:0]        do_w,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              first_elem,
  output logic              last_elem,
  output logic              last_win
);

  localparam logic [3:0] WIN_LIM = 4'(WIN_MAX);

  logic [ADDR_W-1:0] cfg_di_w, cfg_do_w, cfg_xs, cfg_ys;
  logic [3:0]        cfg_sx, cfg_sy, cfg_pw, cfg_ph;
  logic [3:0]        kx, ky;
  logic [ADDR_W-1:0] x, y, ox, oy;
  logic [ADDR_W-1:0] y_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_di_w <= '0;
      cfg_do_w <= '0;
      cfg_xs   <= '0;
      cfg_ys   <= '0;
      cfg_sx   <= '0;
      cfg_sy   <= '0;
      cfg_pw   <= '0;
      cfg_ph   <= '0;
      kx       <= '0;
      ky       <= '0;
      x        <= '0;
      y        <= '0;
      ox       <= '0;
      oy       <= '0;
    end else if (load) begin
      cfg_di_w <= di_w;
      cfg_do_w <= do_w;
      cfg_xs   <= di_x_stop;
      cfg_ys   <= di_y_stop;
      cfg_sx   <= clamp_stride(stride_x);
      cfg_sy   <= clamp_stride(stride_y);
      cfg_pw   <= clamp_win(p_w, WIN_LIM);
      cfg_ph   <= clamp_win(p_h, WIN_LIM);
      kx       <= '0;
      ky       <= '0;
      x        <= '0;
      y        <= '0;
      ox       <= '0;
      oy       <= '0;
    end else if (step) begin
      if (!last_elem) begin
        if (kx == cfg_pw - 4'd1) begin
          kx <= '0;
          ky <= ky + 4'd1;
        end else begin
          kx <= kx + 4'd1;
        end
      end else begin
        kx <= '0;
        ky <= '0;
        // Row end: origin returns to column 0 and steps down one stride.
        if (x == cfg_xs) begin
          x  <= '0;
          ox <= '0;
          y  <= y + {4'd0, cfg_sy};
          oy <= oy + 8'd1;
        end else begin
          x  <= x + {4'd0, cfg_sx};
          ox <= ox + 8'd1;
        end
      end
    end
  end

  assign y_k        = y + {4'd0, ky};
  assign rd_addr    = x + {4'd0, kx} + y_k * cfg_di_w;
  assign wr_addr    = ox + oy * cfg_do_w;
  assign first_elem = (kx == 4'd0) && (ky == 4'd0);
  assign last_elem  = (kx == cfg_pw - 4'd1) && (ky == cfg_ph - 4'd1);
  assign last_win   = (x == cfg_xs) && (y == cfg_ys);

endmodule

`default_nettype wire

// File: rtl/maxpool2d.sv
// ==========================================================================
// maxpool2d : signed int8 2-D max pooling between word-accessed DI/DO buffers
// Rev 1.0
// ==========================================================================
`default_nettype none

module maxpool2d #(
  parameter int DSIZE = 256,
  parameter int PMAX  = conv_pkg::PMAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 di_w,
  input  logic [7:0]                 di_x_stop,
  input  logic [7:0]                 di_y_stop,
  input  logic [3:0]                 stride_x,
  input  logic [3:0]                 stride_y,
  input  logic [3:0]                 p_w,
  input  logic [3:0]                 p_h,
  input  logic [7:0]                 do_w,
  input  logic [$clog2(DSIZE)-3:0]   mi_addr,
  input  logic [31:0]                mi_data,
  input  logic                       mi_wr,
  input  logic [$clog2(DSIZE)-3:0]   mo_addr,
  output logic [31:0]                mo_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done
);

  import conv_pkg::*;

  localparam int BA_W = $clog2(DSIZE);

  state_t state, state_nx;
  logic   load, step;

  logic signed [7:0] di_mem [DSIZE];
  logic signed [7:0] do_mem [DSIZE];
  logic signed [7:0] m;
  logic signed [7:0] elem, base, win_max;

  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              first_elem, last_elem, last_win;

  pool_addr_gen #(
    .WIN_MAX (PMAX)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .di_w       (di_w),
    .di_x_stop  (di_x_stop),
    .di_y_stop  (di_y_stop),
    .stride_x   (stride_x),
    .stride_y   (stride_y),
    .p_w        (p_w),
    .p_h        (p_h),
    .do_w       (do_w),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .first_elem (first_elem),
    .last_elem  (last_elem),
    .last_win   (last_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_elem && last_win) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The first element of a window compares against -128, not the stale max.
  assign elem    = di_mem[rd_addr[BA_W-1:0]];
  assign base    = first_elem ? MIN_S8 : m;
  assign win_max = (elem > base) ? elem : base;

  always_ff @(posedge clk) begin
    if (rst) begin
      m <= MIN_S8;
    end else if (step) begin
      m <= last_elem ? MIN_S8 : win_max;
    end
  end

  // Buffers are never cleared; reset only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && mi_wr && (state == IDLE)) begin
      di_mem[{mi_addr, 2'd0}] <= mi_data[7:0];
      di_mem[{mi_addr, 2'd1}] <= mi_data[15:8];
      di_mem[{mi_addr, 2'd2}] <= mi_data[23:16];
      di_mem[{mi_addr, 2'd3}] <= mi_data[31:24];
    end
    if (!rst && step && last_elem) begin
      do_mem[wr_addr[BA_W-1:0]] <= win_max;
    end
  end

  assign mo_data = {do_mem[{mo_addr, 2'd3}], do_mem[{mo_addr, 2'd2}],
                    do_mem[{mo_addr, 2'd1}], do_mem[{mo_addr, 2'd0}]};

endmodule

`default_nettype wire

// File: doc/maxpool2d.md
MAXPOOL2D -- requirements
Module: maxpool2d

Interface
REQ-001 SHALL have parameter DSIZE, default 256, meaning the byte depth of each of the DI and DO buffers.
REQ-002 SHALL have parameter PMAX, default 4, meaning the maximum pooling window edge.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port di_w, input, 8 bits: input feature-map row pitch in bytes.
REQ-006 SHALL have ports di_x_stop and di_y_stop, input, 8 bits each: last window-origin x and y.
REQ-007 SHALL have ports stride_x and stride_y, input, 4 bits each: window-origin step.
REQ-008 SHALL have ports p_w and p_h, input, 4 bits each: window width and height.
REQ-009 SHALL have port do_w, input, 8 bits: output row pitch in bytes.
REQ-010 SHALL have ports mi_addr (input, $clog2(DSIZE)-2 bits), mi_data (input, 32 bits) and mi_wr (input, 1 bit): the DI word write port.
REQ-011 SHALL have ports mo_addr (input, $clog2(DSIZE)-2 bits) and mo_data (output, 32 bits): the DO word read port.
REQ-012 SHALL have ports start (input, 1 bit), busy (output, 1 bit) and done (output, 1 bit).

Function
REQ-013 SHALL treat DI/DO bytes as signed int8, produced by the upstream conv stage.
REQ-014 SHALL, on mi_wr with busy low, write mi_data bytes [7:0]..[31:24] to DI[4*mi_addr]..DI[4*mi_addr+3]; mi_wr while busy is ignored.
REQ-015 SHALL drive mo_data combinationally as {DO[4*mo_addr+3],..,DO[4*mo_addr]}; DO is readable at any time.
REQ-016 SHALL implement FSM IDLE -> CALC on start; CALC -> FIN after the last write; FIN -> IDLE unconditionally.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL latch all configuration inputs in the IDLE->CALC transition cycle; changes during CALC have no effect.
REQ-019 SHALL visit one window element per CALC cycle, row-major: kx 0..p_w-1 inner, ky 0..p_h-1 outer.
REQ-020 SHALL read element DI[(x+kx) + (y+ky)*di_w], with 8-bit address arithmetic wrapping modulo 256.
REQ-021 SHALL keep running max m, initialised to -128 at each window start, using a signed compare.
REQ-022 SHALL, on the last element of a window, write max(m, element) to DO[ox + oy*do_w], with address wrapping at 8 bits.
REQ-023 SHALL step window origins as follows: x += stride_x and ox += 1 until x == di_x_stop; then x = 0, ox = 0, y += stride_y, oy += 1; the window with x == di_x_stop and y == di_y_stop is the last.
REQ-024 SHALL clamp a p_w or p_h of 0 to 1, and a value above PMAX to PMAX.
REQ-025 SHALL clamp a stride_x or stride_y of 0 to 1.
REQ-026 SHALL take exactly Nwin*p_w*p_h CALC cycles, where Nwin = (di_x_stop/stride_x+1)*(di_y_stop/stride_y+1) when the stops are stride multiples.
REQ-027 SHALL assert busy in CALC and FIN, and deassert it in IDLE.
REQ-028 SHALL pulse done high for exactly one cycle, in FIN.
REQ-029 SHALL permit start in the cycle after done (back-to-back runs).

Reset
REQ-030 SHALL, on rst high at a clock edge, set state IDLE, all counters 0, m to -128, and busy and done to 0, regardless of the current state.
REQ-031 SHALL NOT clear DI or DO on reset; a run aborted by reset leaves DO partially written.
REQ-032 SHALL give rst priority over start and over mi_wr.

Structure
REQ-033 SHALL place the FSM state enum (IDLE, CALC, FIN), PMAX and the address width localparam in shared package conv_pkg.
REQ-034 SHALL place the window/origin counters and address generation in sub-module pool_addr_gen; the compare, DO write and FSM stay in maxpool2d.

Verification
REQ-035 SHALL pass this test: 4x4 DI holding 0..15, di_w=4, p=2x2, stride 2, stops 2/2, do_w=2 -> DO[0..3]=5,7,13,15; done after 16 CALC cycles.
REQ-036 SHALL pass this test: all DI bytes 8'h80 (-128), 2x2 pooling -> every written DO byte = 8'h80.
REQ-037 SHALL pass this test: mixed signs with window {-5,-1,-100,-128} -> output 8'hFF (-1), not 8'h80.
REQ-038 SHALL pass this test: rst asserted in the 5th CALC cycle -> busy=0 and done=0 next cycle; a fresh start yields correct results.
REQ-039 SHALL pass this test: start held high throughout a run plus mi_wr pulses during busy -> a single run occurs and DI is unchanged.
REQ-040 SHALL pass this test: p_w=p_h=0 with stride 1, stops 3/0, do_w=4 -> DO[0..3] = DI[0..3] (copy); done after 4 cycles.
